// File: rtl/nbits_pipelined_adder.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES chunks of W bits.
// Skew registers carry the pending operand bits and the finished sum bits with each beat.
module nbits_pipelined_adder #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / STAGES;

  if (N < 1 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_check
    $error("nbits_pipelined_adder: STAGES must divide N and lie in 1..N");
  end

  logic         w_adv;
  logic [N-1:0] w_bb;
  logic         w_c0;

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_bb     = sub ? ~b : b;
  assign w_c0     = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W;   // sum bits already finished before this stage
    localparam int HI = N - LO;  // operand bits still pending, this chunk included

    logic [HI-1:0]   w_a;
    logic [HI-1:0]   w_b;
    logic            w_c;
    logic            w_v;
    logic [W:0]      w_chunk;
    logic [LO+W-1:0] w_sum;
    logic            r_v;
    logic            r_c;
    logic [LO+W-1:0] r_sum;

    assign w_chunk = {1'b0, w_a[W-1:0]} + {1'b0, w_b[W-1:0]} + {{W{1'b0}}, w_c};

    if (k == 0) begin : g_head
      assign w_a   = a;
      assign w_b   = w_bb;
      assign w_c   = w_c0;
      assign w_v   = in_valid;
      assign w_sum = w_chunk[W-1:0];
    end else begin : g_body
      assign w_a   = g_st[k-1].g_skew.r_a;
      assign w_b   = g_st[k-1].g_skew.r_b;
      assign w_c   = g_st[k-1].r_c;
      assign w_v   = g_st[k-1].r_v;
      assign w_sum = {w_chunk[W-1:0], g_st[k-1].r_sum};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_v   <= w_v;
        r_c   <= w_chunk[W];
        r_sum <= w_sum;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [HI-W-1:0] r_a;
      logic [HI-W-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[HI-1:W];
          r_b <= w_b[HI-1:W];
        end
      end
    end else begin : g_tail
      logic r_ovf;

      // The top chunk still sees both operand sign bits, so overflow is resolved here.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_a[HI-1] == w_b[HI-1]) && (w_chunk[W-1] != w_a[HI-1]);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_v;
  assign s         = g_st[STAGES-1].r_sum;
  assign cout      = g_st[STAGES-1].r_c;
  assign ovf       = g_st[STAGES-1].g_tail.r_ovf;

endmodule

// File: doc/nbits_pipelined_adder.md
Name: nbits_pipelined_adder

Overview:
- Parametrised, pipelined successor to the N-bit ripple adder.
- Splits the N-bit carry chain into STAGES registered chunks of W = N/STAGES bits, so wide adds close timing at high clock rates.
- Adds add/subtract mode, a signed-overflow flag, and a valid/ready stream handshake with backpressure.
- Sits in datapaths (accumulators, address generators) that feed and drain through stream interfaces.

Parameters:
- N, 16, operand/result width in bits; N >= 1.
- STAGES, 4, number of pipeline stages. 1 <= STAGES <= N, and N % STAGES == 0 (elaboration-time assertion). W = N/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  N  operand A (unsigned/two's complement)
- b  input  N  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: s = a + b + cin; 1: s = a - b - cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- s  output  N  result, modulo 2^N
- cout  output  1  add: carry-out; sub: 1 = no borrow, 0 = borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits cleared; out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 in the cycle after reset (pipeline empty).
  - in-flight beats are discarded; no partial result is ever presented.
- Arithmetic:
  - Effective operands: bb = sub ? ~b : b; c0 = sub ? ~cin : cin. Result is a + bb + c0.
  - Stage k (0..STAGES-1) adds bits [k*W +: W] using the carry registered from stage k-1 (stage 0 uses c0).
  - Lower finished sum bits and the not-yet-used upper operand bits travel with the beat (skew registers).
  - cout = carry out of bit N-1.
  - ovf = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]).
- Handshake:
  - Global stall model: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - A beat is accepted when in_valid && in_ready. All stage registers shift only when adv=1.
  - When adv=0, every stage holds, and s/cout/ovf/out_valid are stable.
  - Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
  - Results leave in acceptance order; no beat is dropped or duplicated.
- Latency:
  - An accepted beat appears on out_valid exactly STAGES cycles later, provided adv stays 1.
  - Each stall cycle adds one cycle of latency.
  - Throughput is 1 beat/cycle when out_ready stays 1.
  - STAGES=1 degenerates to a single registered N-bit adder with latency 1.
- Boundaries:
  - Wrap-around is modulo 2^N: 0xFFFF+1 gives 0x0000, cout=1.
  - A carry crossing every chunk boundary is resolved correctly through all stages.
  - Simultaneous out handshake and new input in the same cycle is legal: full rate is sustained.
  - Mode (sub) and cin are sampled per beat; mixing add and sub beats back-to-back is legal.
  - rst has priority over the handshake.
  - If in_valid is deasserted while in_ready=0, nothing is captured.

Test Plan (N=16, STAGES=4):
1. Single add: a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, s=0x0100, cout=0, ovf=0.
2. Full carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1, cin=1 -> s=0x7FFE, cout=1, ovf=1.
4. Streaming with backpressure:
   - Stimulus: 8 back-to-back beats a=i, b=0x1000, i=0..7; hold out_ready=0 for cycles 6-8.
   - Required: in_ready=0 exactly while out_valid && !out_ready; outputs 0x1000..0x1007 in order, no loss or duplicate; s stable during the stall.
5. Reset mid-flight: accept 3 beats, assert rst for 1 cycle before any result emerges -> out_valid stays 0 afterwards with no stale output; the next beat (0x0002+0x0003) gives s=0x0005 after 4 cycles.
6. Randomised mix of add/sub, cin, bubbles and out_ready toggling (>=10k beats) checked against a reference-model scoreboard. Repeat with STAGES=1 and STAGES=16.
